// File: rtl/block_geometry_pkg.sv
// Block-field geometry, address type, level patterns and arbiter states shared by the BlockState port-A logic.
package block_geometry_pkg;

    localparam int unsigned BLOCK_COLS = 12;
    localparam int unsigned BLOCK_ROWS = 6;
    localparam int unsigned DUMMY_ADDR = BLOCK_COLS * BLOCK_ROWS;
    localparam int unsigned ADDR_W     = 7;
    localparam int unsigned ROW_W      = 3;
    localparam int unsigned COL_W      = 4;

    typedef logic [ADDR_W-1:0] block_addr_t;

    localparam block_addr_t          DUMMY_BA = block_addr_t'(DUMMY_ADDR);
    localparam block_addr_t          LAST_BA  = block_addr_t'(DUMMY_ADDR - 1);
    localparam logic [ROW_W-1:0]     ROW_LAST = ROW_W'(BLOCK_ROWS - 1);
    localparam logic [COL_W-1:0]     COL_LAST = COL_W'(BLOCK_COLS - 1);

    typedef enum logic [1:0] {
        LVL_FULL    = 2'd0,
        LVL_CHECKER = 2'd1,
        LVL_ROWS    = 2'd2,
        LVL_RING    = 2'd3
    } level_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_SCAN = 2'd2
    } arb_state_e;

    // One port-A command: address, write enable, write data.
    typedef struct packed {
        block_addr_t addr;
        logic        we;
        logic        wdata;
    } mem_cmd_t;

endpackage

// File: rtl/block_state_arbiter_if.sv
// Physics-side and BlockState port-A signals of the block state arbiter.
interface block_state_arbiter_if;
    import block_geometry_pkg::*;

    logic        PHYS_REQ;
    block_addr_t PHYS_ADDR;
    logic        PHYS_WE;
    logic        PHYS_WDATA;
    logic        PHYS_RDATA;
    logic        PHYS_GNT;
    block_addr_t MEM_ADDR;
    logic        MEM_WE;
    logic        MEM_WDATA;
    logic        MEM_RDATA;

    modport slave (
        input  PHYS_REQ, PHYS_ADDR, PHYS_WE, PHYS_WDATA, MEM_RDATA,
        output PHYS_RDATA, PHYS_GNT, MEM_ADDR, MEM_WE, MEM_WDATA
    );

    modport master (
        output PHYS_REQ, PHYS_ADDR, PHYS_WE, PHYS_WDATA, MEM_RDATA,
        input  PHYS_RDATA, PHYS_GNT, MEM_ADDR, MEM_WE, MEM_WDATA
    );

endinterface

// File: rtl/block_state_arbiter_level_pattern.sv
// level_pattern: combinational alive bit for a (level, row, col) block position.
module level_pattern
    import block_geometry_pkg::*;
(
    input  level_sel_e       level_sel,
    input  logic [ROW_W-1:0] row,
    input  logic [COL_W-1:0] col,
    output logic             alive
);

    always_comb begin
        alive = 1'b0;
        case (level_sel)
            LVL_FULL:    alive = 1'b1;
            LVL_CHECKER: alive = ~(row[0] ^ col[0]);
            LVL_ROWS:    alive = ~row[0];
            LVL_RING:    alive = (row == '0) || (row == ROW_LAST) ||
                                 (col == '0) || (col == COL_LAST);
        endcase
    end

endmodule

// File: rtl/block_state_arbiter.sv
// Shares BlockState port A between physics, the level-fill sequencer and the alive-block scanner.
// Define BLOCK_ARB_ADDR_GUARD_EN to drop physics writes at/above the dummy address and expose GUARD_HIT.
module block_state_arbiter
    import block_geometry_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RESET_N,
    block_state_arbiter_if.slave  bus,
    input  logic                  LOAD_LEVEL,
    input  logic [1:0]            LEVEL_SEL,
    output logic [ADDR_W-1:0]     ALIVE_COUNT,
    output logic                  LEVEL_CLEARED,
    output logic                  BUSY
`ifdef BLOCK_ARB_ADDR_GUARD_EN
    ,
    output logic                  GUARD_HIT
`endif
);

    arb_state_e        state_q, state_d;
    level_sel_e        level_sel_q, level_sel_d;
    block_addr_t       fill_addr_q, fill_addr_d;
    block_addr_t       scan_addr_q, scan_addr_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic              read_pending_q, read_pending_d;
    logic              last_pending_q, last_pending_d;
    logic              level_loaded_q, level_loaded_d;
    logic              level_cleared_q, level_cleared_d;
    logic [ADDR_W-1:0] acc_q, acc_d;
    logic [ADDR_W-1:0] alive_count_q, alive_count_d;
    logic [ADDR_W-1:0] total_c;
    logic              pattern_bit_c;
    logic              phys_pass_c;
    mem_cmd_t          phys_cmd_c;
    mem_cmd_t          cmd_c;
`ifdef BLOCK_ARB_ADDR_GUARD_EN
    logic              guard_hit_q, guard_hit_d;
    logic              guard_drop_c;
`endif

    level_pattern u_pattern (
        .level_sel (level_sel_q),
        .row       (row_q),
        .col       (col_q),
        .alive     (pattern_bit_c)
    );

    // Physics command as it would reach the RAM when physics owns the port.
    always_comb begin
        phys_cmd_c.addr  = bus.PHYS_ADDR;
        phys_cmd_c.we    = bus.PHYS_WE;
        phys_cmd_c.wdata = bus.PHYS_WDATA;
`ifdef BLOCK_ARB_ADDR_GUARD_EN
        guard_drop_c = bus.PHYS_WE && (bus.PHYS_ADDR >= DUMMY_BA);
        if (guard_drop_c) begin
            phys_cmd_c.we = 1'b0;
        end
`endif
    end

    always_comb begin
        state_d         = state_q;
        level_sel_d     = level_sel_q;
        fill_addr_d     = fill_addr_q;
        scan_addr_d     = scan_addr_q;
        row_d           = row_q;
        col_d           = col_q;
        read_pending_d  = 1'b0;
        last_pending_d  = 1'b0;
        level_loaded_d  = level_loaded_q;
        level_cleared_d = level_cleared_q;
        acc_d           = acc_q;
        alive_count_d   = alive_count_q;
        cmd_c           = '0;
        total_c         = acc_q + ADDR_W'(bus.MEM_RDATA);
        phys_pass_c     = bus.PHYS_REQ && (state_q != ST_FILL);
`ifdef BLOCK_ARB_ADDR_GUARD_EN
        guard_hit_d     = guard_hit_q;
        if (phys_pass_c && guard_drop_c) begin
            guard_hit_d = 1'b1;
        end
`endif

        case (state_q)
            ST_IDLE: begin
                if (phys_pass_c) begin
                    cmd_c = phys_cmd_c;
                end
            end
            ST_FILL: begin
                cmd_c.addr  = fill_addr_q;
                cmd_c.we    = 1'b1;
                cmd_c.wdata = (fill_addr_q == DUMMY_BA) ? 1'b0 : pattern_bit_c;
                if (fill_addr_q == DUMMY_BA) begin
                    state_d        = ST_SCAN;
                    level_loaded_d = 1'b1;
                    acc_d          = '0;
                    scan_addr_d    = '0;
                end else begin
                    fill_addr_d = fill_addr_q + 1'b1;
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            ST_SCAN: begin
                // Read data lands one cycle after the scanner's read, whoever owns the port now.
                if (read_pending_q) begin
                    if (last_pending_q) begin
                        alive_count_d   = total_c;
                        level_cleared_d = (total_c == '0) && level_loaded_q;
                        acc_d           = '0;
                    end else begin
                        acc_d = total_c;
                    end
                end
                if (phys_pass_c) begin
                    cmd_c = phys_cmd_c;
                end else begin
                    cmd_c.addr     = scan_addr_q;
                    read_pending_d = 1'b1;
                    last_pending_d = (scan_addr_q == LAST_BA);
                    scan_addr_d    = (scan_addr_q == LAST_BA) ? '0 : scan_addr_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A level load wins over everything, including a fill already under way.
        if (LOAD_LEVEL) begin
            state_d         = ST_FILL;
            level_sel_d     = level_sel_e'(LEVEL_SEL);
            fill_addr_d     = '0;
            row_d           = '0;
            col_d           = '0;
            scan_addr_d     = '0;
            acc_d           = '0;
            read_pending_d  = 1'b0;
            last_pending_d  = 1'b0;
            level_cleared_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q         <= ST_IDLE;
            level_sel_q     <= LVL_FULL;
            fill_addr_q     <= '0;
            scan_addr_q     <= '0;
            row_q           <= '0;
            col_q           <= '0;
            read_pending_q  <= 1'b0;
            last_pending_q  <= 1'b0;
            level_loaded_q  <= 1'b0;
            level_cleared_q <= 1'b0;
            acc_q           <= '0;
            alive_count_q   <= '0;
`ifdef BLOCK_ARB_ADDR_GUARD_EN
            guard_hit_q     <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            level_sel_q     <= level_sel_d;
            fill_addr_q     <= fill_addr_d;
            scan_addr_q     <= scan_addr_d;
            row_q           <= row_d;
            col_q           <= col_d;
            read_pending_q  <= read_pending_d;
            last_pending_q  <= last_pending_d;
            level_loaded_q  <= level_loaded_d;
            level_cleared_q <= level_cleared_d;
            acc_q           <= acc_d;
            alive_count_q   <= alive_count_d;
`ifdef BLOCK_ARB_ADDR_GUARD_EN
            guard_hit_q     <= guard_hit_d;
`endif
        end
    end

    assign bus.MEM_ADDR   = cmd_c.addr;
    assign bus.MEM_WE     = cmd_c.we;
    assign bus.MEM_WDATA  = cmd_c.wdata;
    assign bus.PHYS_RDATA = bus.MEM_RDATA;
    assign bus.PHYS_GNT   = (state_q != ST_FILL);
    assign BUSY           = (state_q == ST_FILL);
    assign ALIVE_COUNT    = alive_count_q;
    assign LEVEL_CLEARED  = level_cleared_q && !LOAD_LEVEL;
`ifdef BLOCK_ARB_ADDR_GUARD_EN
    assign GUARD_HIT      = guard_hit_q;
`endif

endmodule

// File: tb/tb_block_state_arbiter.sv
// Directed bench for block_state_arbiter with a registered-read BlockState port-A model.
module tb_block_state_arbiter;
    import block_geometry_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load_level;
    logic [1:0] level_sel;
    logic [6:0] alive_count;
    logic       level_cleared;
    logic       busy;
`ifdef BLOCK_ARB_ADDR_GUARD_EN
    logic       guard_hit;
`endif
    logic       ram [0:72];
    int         n_chk = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    block_state_arbiter_if bus ();

    block_state_arbiter dut (
        .CLK           (clk),
        .RESET_N       (rst_n),
        .bus           (bus),
        .LOAD_LEVEL    (load_level),
        .LEVEL_SEL     (level_sel),
        .ALIVE_COUNT   (alive_count),
        .LEVEL_CLEARED (level_cleared),
        .BUSY          (busy)
`ifdef BLOCK_ARB_ADDR_GUARD_EN
        ,
        .GUARD_HIT     (guard_hit)
`endif
    );

    // BlockState port A: one-cycle registered read, entry 72 always reads 0.
    always @(posedge clk) begin
        if (bus.MEM_WE && bus.MEM_ADDR <= 7'd72) ram[bus.MEM_ADDR] <= bus.MEM_WDATA;
        bus.MEM_RDATA <= (bus.MEM_ADDR >= 7'd72) ? 1'b0 : ram[bus.MEM_ADDR];
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    function automatic logic exp_alive(input logic [1:0] sel, input int a);
        int r;
        int c;
        if (a >= 72) return 1'b0;
        r = a / 12;
        c = a % 12;
        case (sel)
            2'd0:    return 1'b1;
            2'd1:    return ((r + c) % 2) == 0;
            2'd2:    return (r % 2) == 0;
            default: return (r == 0) || (r == 5) || (c == 0) || (c == 11);
        endcase
    endfunction

    // Pulse LOAD_LEVEL and check all 73 fill writes.
    task automatic fill_and_check(input logic [1:0] sel);
        cyc();
        load_level = 1'b1;
        level_sel  = sel;
        #4;
        check("cleared_low_on_load", 32'(level_cleared), 0);
        cyc();
        load_level = 1'b0;
        for (int i = 0; i < 73; i++) begin
            if (i > 0) cyc();
            #4;
            check("fill_busy", 32'(busy), 1);
            check("fill_gnt", 32'(bus.PHYS_GNT), 0);
            check("fill_we", 32'(bus.MEM_WE), 1);
            check("fill_addr", 32'(bus.MEM_ADDR), i);
            check("fill_data", 32'(bus.MEM_WDATA), 32'(exp_alive(sel, i)));
        end
        cyc();
        #4;
        check("post_fill_busy", 32'(busy), 0);
        check("post_fill_gnt", 32'(bus.PHYS_GNT), 1);
        check("scan_start_addr", 32'(bus.MEM_ADDR), 0);
        check("scan_we", 32'(bus.MEM_WE), 0);
    endtask

    // Run one scan pass from its first read; optional physics reads on odd cycles.
    task automatic scan_pass(input int len, input int old_cnt, input int new_cnt, input bit alt);
        for (int k = 1; k <= len; k++) begin
            cyc();
            bus.PHYS_REQ  = alt && (k % 2 == 1);
            bus.PHYS_WE   = 1'b0;
            bus.PHYS_ADDR = 7'(k % 73);
            #4;
            if (k < len - 1) begin
                if (bus.PHYS_REQ) check("phys_owns_port", 32'(bus.MEM_ADDR), k % 73);
                else check("scan_addr", 32'(bus.MEM_ADDR), alt ? k / 2 : k);
            end
            if (k == len - 1) check("count_before_pass_end", 32'(alive_count), old_cnt);
            if (k == len) check("count_after_pass", 32'(alive_count), new_cnt);
        end
        bus.PHYS_REQ = 1'b0;
    endtask

    initial begin
        bit seen;
        int s;
        rst_n          = 1'b0;
        load_level     = 1'b0;
        level_sel      = 2'd0;
        bus.PHYS_REQ   = 1'b0;
        bus.PHYS_ADDR  = '0;
        bus.PHYS_WE    = 1'b0;
        bus.PHYS_WDATA = 1'b0;

        repeat (2) cyc();
        #4;
        check("rst_busy", 32'(busy), 0);
        check("rst_gnt", 32'(bus.PHYS_GNT), 1);
        check("rst_count", 32'(alive_count), 0);
        check("rst_cleared", 32'(level_cleared), 0);
        check("rst_mem_we", 32'(bus.MEM_WE), 0);
        check("rst_mem_addr", 32'(bus.MEM_ADDR), 0);
        check("rst_mem_wdata", 32'(bus.MEM_WDATA), 0);
`ifdef BLOCK_ARB_ADDR_GUARD_EN
        check("rst_guard_hit", 32'(guard_hit), 0);
`endif
        cyc();
        rst_n = 1'b1;

        // Physics write then read in IDLE.
        cyc();
        bus.PHYS_REQ = 1'b1; bus.PHYS_WE = 1'b1; bus.PHYS_ADDR = 7'd5; bus.PHYS_WDATA = 1'b1;
        #4;
        check("idle_phys_we", 32'(bus.MEM_WE), 1);
        check("idle_phys_addr", 32'(bus.MEM_ADDR), 5);
        check("idle_phys_wdata", 32'(bus.MEM_WDATA), 1);
        cyc();
        bus.PHYS_WE = 1'b0;
        cyc();
        bus.PHYS_REQ = 1'b0;
        #4;
        check("idle_phys_rdata", 32'(bus.PHYS_RDATA), 1);

`ifdef BLOCK_ARB_ADDR_GUARD_EN
        check("guard_clear_after_legal_write", 32'(guard_hit), 0);
        cyc();
        bus.PHYS_REQ = 1'b1; bus.PHYS_WE = 1'b1; bus.PHYS_ADDR = 7'd72; bus.PHYS_WDATA = 1'b1;
        #4;
        check("guard_we_dropped", 32'(bus.MEM_WE), 0);
        check("guard_addr_passes", 32'(bus.MEM_ADDR), 72);
        cyc();
        bus.PHYS_WE = 1'b0;
        #4;
        check("guard_hit_set", 32'(guard_hit), 1);
        cyc();
        bus.PHYS_REQ = 1'b0;
        #4;
        check("guard_read72_zero", 32'(bus.PHYS_RDATA), 0);
        check("guard_hit_sticky", 32'(guard_hit), 1);
`endif

        // Fill timing and full level.
        fill_and_check(2'd0);
        scan_pass(73, 0, 72, 1'b0);
        check("full_not_cleared", 32'(level_cleared), 0);

        // Checkerboard with physics reads on alternate cycles.
        fill_and_check(2'd1);
        check("checker_ram13", 32'(ram[13]), 1);
        scan_pass(144, 72, 36, 1'b1);

        fill_and_check(2'd2);
        check("rows_ram12", 32'(ram[12]), 0);
        check("rows_ram24", 32'(ram[24]), 1);
        scan_pass(73, 36, 36, 1'b0);

        fill_and_check(2'd3);
        check("ring_ram13", 32'(ram[13]), 0);
        scan_pass(73, 36, 32, 1'b0);

        // Physics clears every block.
        for (int a = 0; a < 72; a++) begin
            cyc();
            bus.PHYS_REQ = 1'b1; bus.PHYS_WE = 1'b1; bus.PHYS_WDATA = 1'b0; bus.PHYS_ADDR = 7'(a);
        end
        cyc();
        bus.PHYS_REQ = 1'b0; bus.PHYS_WE = 1'b0;
        s = 0;
        for (int a = 0; a < 72; a++) s += int'(ram[a]);
        check("ram_all_cleared", s, 0);
        seen = 1'b0;
        for (int k = 0; k < 160; k++) begin
            if (!seen) begin
                cyc();
                #4;
                seen = (level_cleared === 1'b1);
            end
        end
        check("cleared_within_two_passes", 32'(seen), 1);
        check("cleared_count_zero", 32'(alive_count), 0);

        // Load drops LEVEL_CLEARED at once; reload at fill cycle 30; reset at fill cycle 40.
        cyc();
        load_level = 1'b1; level_sel = 2'd0;
        #4;
        check("cleared_drops_on_load", 32'(level_cleared), 0);
        cyc();
        load_level = 1'b0;
        #4;
        check("fill1_addr", 32'(bus.MEM_ADDR), 0);
        for (int i = 1; i <= 30; i++) begin
            cyc();
            if (i == 30) begin
                load_level = 1'b1; level_sel = 2'd2;
            end
            #4;
            check("fill1_addr", 32'(bus.MEM_ADDR), i);
        end
        cyc();
        load_level = 1'b0;
        #4;
        check("restart_addr", 32'(bus.MEM_ADDR), 0);
        check("restart_data", 32'(bus.MEM_WDATA), 32'(exp_alive(2'd2, 0)));
        for (int i = 1; i <= 40; i++) begin
            cyc();
            if (i == 40) rst_n = 1'b0;
            #4;
            check("fill2_addr", 32'(bus.MEM_ADDR), i);
            check("fill2_data", 32'(bus.MEM_WDATA), 32'(exp_alive(2'd2, i)));
        end
        cyc();
        rst_n = 1'b1;
        #4;
        check("midfill_rst_busy", 32'(busy), 0);
        check("midfill_rst_gnt", 32'(bus.PHYS_GNT), 1);
        check("midfill_rst_count", 32'(alive_count), 0);
        check("midfill_rst_cleared", 32'(level_cleared), 0);
        check("midfill_rst_we", 32'(bus.MEM_WE), 0);
        repeat (100) cyc();
        #4;
        check("idle_stays_uncleared", 32'(level_cleared), 0);
        check("idle_count_zero", 32'(alive_count), 0);
        check("idle_busy", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/block_state_arbiter.md
Name: block_state_arbiter

Overview:
- Owns port A of the BlockState RAM (73 entries: blocks 0..71 plus dummy entry 72, which always reads 0) and shares it between the physics engine and two internal sequencers.
- The level-fill sequencer writes a new block pattern on demand.
- The background scanner counts alive blocks and flags a cleared level.
- Sits between GamePhysics and BlockState; the top-level game FSM drives LOAD_LEVEL and consumes LEVEL_CLEARED.

Parameters:
- BLOCK_COLS, 12, blocks per row.
- BLOCK_ROWS, 6, block rows.
- DUMMY_ADDR, 72, address of the always-zero entry (equals BLOCK_COLS*BLOCK_ROWS).

Ports:
- CLK  in  1  clock
- RESET_N  in  1  synchronous active-low reset
- PHYS_REQ  in  1  physics drives port A this cycle
- PHYS_ADDR  in  7  physics address
- PHYS_WE  in  1  physics write enable
- PHYS_WDATA  in  1  physics write data
- PHYS_RDATA  out  1  read data to physics (MEM_RDATA passthrough)
- PHYS_GNT  out  1  physics may use the port; physics holds START_UPDATE off while low
- LOAD_LEVEL  in  1  one-cycle pulse: start fill
- LEVEL_SEL  in  2  pattern, sampled with LOAD_LEVEL
- MEM_ADDR  out  7  to BlockState A_ADDR
- MEM_WE  out  1  to A_WRITE_ENABLE
- MEM_WDATA  out  1  to A_IN
- MEM_RDATA  in  1  from A_OUT (registered RAM, 1-cycle latency)
- ALIVE_COUNT  out  7  alive blocks from the last complete scan
- LEVEL_CLEARED  out  1  level empty
- BUSY  out  1  fill in progress

Behaviour:
- Reset (RESET_N low at a CLK edge):
  - state IDLE, ALIVE_COUNT=0, LEVEL_CLEARED=0, BUSY=0, PHYS_GNT=1.
  - MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0.
  - levelLoaded=0, scan address=0, accumulator=0.
  - RAM contents are not touched; reset during FILL leaves a partial pattern, and the game FSM must issue LOAD_LEVEL again.
- States:
  - IDLE: only physics uses the port. Go to FILL on LOAD_LEVEL.
  - FILL:
    - BUSY=1, PHYS_GNT=0, PHYS_REQ ignored.
    - One write per cycle to addresses 0..72, in order. Row and column counters advance in step; no divider.
    - MEM_WDATA = pattern(row, col). Address 72 is written 0.
    - After the write to 72: go to SCAN, set levelLoaded=1, accumulator=0, scan address=0.
    - Takes exactly 73 cycles; BUSY falls on the cycle after the last write.
  - SCAN:
    - Physics has absolute priority. If PHYS_REQ=1, the physics signals pass combinationally to MEM_*; the scanner stalls and holds its address.
    - If PHYS_REQ=0: MEM_ADDR=scan address, MEM_WE=0, scan address increments, readPending=1 for the next cycle.
    - A cycle with readPending=1 adds MEM_RDATA to the accumulator, regardless of who owns the port in that cycle.
    - When the sample for address 71 is accumulated: ALIVE_COUNT <= total; LEVEL_CLEARED <= (total==0) && levelLoaded; accumulator and scan address restart at 0. Scanning is continuous.
- LOAD_LEVEL:
  - Accepted in any state, including FILL, where it restarts the fill from address 0 with the new LEVEL_SEL.
  - Clears LEVEL_CLEARED in the same cycle.
  - Abandons any partial scan.
- Patterns (r = row 0..5, c = col 0..11):
  - 0: all alive (72).
  - 1: checkerboard, alive when (r+c) is even (36).
  - 2: even rows (36).
  - 3: outer ring, alive when r is 0 or 5, or c is 0 or 11 (32).
- Count staleness: a physics write may hit an address already scanned this pass. ALIVE_COUNT is then stale by at most one pass; this is accepted.
- Scanner never writes. Physics write data is never modified, except under the macro below.

Optional Feature:
- Macro BLOCK_ARB_ADDR_GUARD_EN.
- When defined:
  - Physics writes with PHYS_ADDR >= DUMMY_ADDR are dropped (MEM_WE forced 0); reads still pass.
  - Sticky output GUARD_HIT (1 bit, reset 0) is set on the first dropped write.
- When undefined: no GUARD_HIT port, and physics writes pass unfiltered.

Decomposition:
- Shared package block_geometry_pkg:
  - BLOCK_COLS, BLOCK_ROWS, DUMMY_ADDR.
  - 7-bit block-address typedef.
  - 2-bit level-select enum (LVL_FULL, LVL_CHECKER, LVL_ROWS, LVL_RING).
  - 2-bit arbiter state enum.
- One sub-module, level_pattern: combinational (LEVEL_SEL, row, col) -> alive bit. Shared later with an attract-mode renderer.

Test Plan:
- Fill timing: reset, then LOAD_LEVEL with LEVEL_SEL=0 -> BUSY high for exactly 73 cycles, PHYS_GNT=0 throughout, writes to addresses 0..72 with data 1 except address 72 = 0. After the first full scan, ALIVE_COUNT=72 and LEVEL_CLEARED=0.
- Pattern counts: LEVEL_SEL=1/2/3 -> ALIVE_COUNT=36/36/32. RAM model shows address 13 (r1,c1) = 1 for checkerboard and 0 for ring.
- Physics priority: PHYS_REQ=1 on alternate cycles during SCAN -> MEM_ADDR equals PHYS_ADDR on those cycles, the scan pass takes 144 cycles, and the count is still correct.
- Cleared level: physics writes 0 to all 72 blocks after a LEVEL_SEL=3 fill -> within two scan passes ALIVE_COUNT=0 and LEVEL_CLEARED=1. A following LOAD_LEVEL drops LEVEL_CLEARED in the same cycle.
- Restart and reset: LOAD_LEVEL at fill cycle 30 -> fill restarts at address 0. RESET_N low at fill cycle 40 -> IDLE, BUSY=0, PHYS_GNT=1, ALIVE_COUNT=0, and LEVEL_CLEARED stays 0 with no level loaded.
- Guard (BLOCK_ARB_ADDR_GUARD_EN defined): physics write of 1 to address 72 -> MEM_WE=0, GUARD_HIT=1, and a later read of 72 returns 0.
